axis_switch_rr_master: RTL and testbench
========================================

// Module: axis_switch_rr_master
// PURPOSE
// N:1 AXI-Stream switch, successor to the single-master switch: same grant/lock scheme, plus
// selectable round-robin or fixed-priority arbitration, packet lock on TLAST, optional source-index
// tagging on TID, and a registered 2-entry output slice (no comb path m_ready->s_ready).
// Sits in front of the manager command/queue consumers, merging accelerator streams.
// PARAMETERS
// NSLAVES     2   number of slave ports (>=1)
// DATA_WIDTH  64  TDATA width
// DEST_WIDTH  1   TDEST width
// ID_WIDTH    1   TID width; if ID_SRC=1, must be >= $clog2(NSLAVES)
// HAS_DEST    0   1: forward s_dest; 0: m_dest='0
// HAS_LAST    0   1: grant held until s_last beat accepted; 0: one beat per grant; m_last='0
// HAS_ID      0   1: forward s_id (ignored if ID_SRC=1); 0: m_id='0
// ARB_MODE    1   0: fixed priority (lowest index wins); 1: round-robin
// ID_SRC      0   1: m_id = granted slave index, zero-extended
// PORTS
// aclk     in  1                     clock
// aresetn  in  1                     reset, synchronous, active-low
// s_valid  in  NSLAVES               per-slave TVALID
// s_ready  out NSLAVES               per-slave TREADY
// s_data   in  NSLAVES*DATA_WIDTH    packed TDATA, slave j at [j*DATA_WIDTH +: DATA_WIDTH]
// s_dest   in  NSLAVES*DEST_WIDTH    packed TDEST
// s_id     in  NSLAVES*ID_WIDTH      packed TID
// s_last   in  NSLAVES               per-slave TLAST
// m_valid  out 1 / m_ready in 1      master handshake
// m_data/m_dest/m_id/m_last out DATA_WIDTH/DEST_WIDTH/ID_WIDTH/1  master payload
// BEHAVIOUR
// - Reset aresetn, synchronous, active-low; clock aclk. Reset: state=IDLE, rr_ptr=0, slice
//   empty, m_valid=0, s_ready='0, m_* payload=0. Reset mid-packet drops in-flight beats.
// - FSM IDLE: s_ready='0. If any s_valid: grant<=arbiter pick, state<=XFER (1-cycle bubble).
//   ARB_MODE=1: first valid index searching rr_ptr, rr_ptr+1, ... wrapping at NSLAVES-1->0.
//   ARB_MODE=0: lowest valid index.
// - XFER: s_ready[grant]=(slice count<2); all other s_ready=0. Beat accepted when
//   s_valid[grant]&&s_ready[grant]; pushed into slice with data/dest/last/id per params.
//   End of grant: HAS_LAST=0 -> first accepted beat; HAS_LAST=1 -> accepted beat with
//   s_last[grant]=1. On end: state<=IDLE, rr_ptr<=(grant==NSLAVES-1)?0:grant+1.
//   Requests from other slaves during XFER are ignored until IDLE; s_valid drop mid-packet
//   holds the grant (no timeout).
// - Output slice: 2-entry FIFO, count 0..2. m_valid=(count!=0), payload=head entry, all
//   registered. Push and pop in same cycle: count unchanged. Accepted beat visible on m_* the
//   next cycle (latency 1). Full throughput 1 beat/cycle with m_ready=1; order preserved; no
//   beat lost or duplicated under any m_ready pattern. Slice drains independently of FSM,
//   so IDLE bubbles never stall m_*.
// - NSLAVES=1: same datapath; grant always 0.
// - AXIS rule: m_valid, once high, stays high with stable payload until m_ready.
// TESTING
// 1 aresetn=0 3 cycles, s_valid=4'b1111 -> m_valid=0, s_ready=0; after release grant=0 on cycle 2.
// 2 NSLAVES=4, ARB_MODE=1, ID_SRC=1, HAS_LAST=0, all valid, m_ready=1 -> m_id 0,1,2,3,0,1...
// 3 HAS_LAST=1, slave2 sends 5-beat pkt, slave0 valid from beat 2 -> s_ready[0]=0 until
//   slave2 last beat accepted; next packet out is slave0; m_last on beat 5 only.
// 4 m_ready=0 for 4 cycles mid-packet -> 2 beats buffered, s_ready[grant] falls; resumed
//   output data sequence exactly 0x10..0x17, no gaps after restart.
// 5 ARB_MODE=0, slaves 1 and 3 always valid, HAS_LAST=0 -> only slave 1 beats appear.
// 6 aresetn=0 during beat 3 of a packet -> m_valid=0 next cycle, rr_ptr=0, fresh arbitration.

Source files
------------

// File: rtl/axis_switch_rr_master.sv
// axis_switch_rr_master: N:1 AXI-Stream switch with round-robin or fixed-priority
// arbitration, optional packet lock on TLAST, optional TID source tagging and a
// registered 2-entry output slice (no combinational m_ready -> s_ready path).
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_valid/s_ready        per-slave handshake (NSLAVES bits each)
//   s_data/s_dest/s_id     packed per-slave payload, slave j at [j*W +: W]
//   s_last                 per-slave TLAST
//   m_valid/m_ready        master handshake
//   m_data/m_dest/m_id/m_last  master payload (registered)
module axis_switch_rr_master #(
  parameter int unsigned NSLAVES    = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned HAS_DEST   = 0,
  parameter int unsigned HAS_LAST   = 0,
  parameter int unsigned HAS_ID     = 0,
  parameter int unsigned ARB_MODE   = 1,
  parameter int unsigned ID_SRC     = 0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NSLAVES-1:0]               s_valid,
  output logic [NSLAVES-1:0]               s_ready,
  input  logic [NSLAVES*DATA_WIDTH-1:0]    s_data,
  input  logic [NSLAVES*DEST_WIDTH-1:0]    s_dest,
  input  logic [NSLAVES*ID_WIDTH-1:0]      s_id,
  input  logic [NSLAVES-1:0]               s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [DEST_WIDTH-1:0]            m_dest,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic                             m_last
);

  localparam int unsigned IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   grant, grant_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   pick, cand;
  logic               found;
  logic [NSLAVES-1:0] s_ready_nxt;

  logic [1:0]            count, count_nxt;
  logic                  push, pop, end_grant;
  logic [DATA_WIDTH-1:0] in_data, sk_data;
  logic [DEST_WIDTH-1:0] in_dest, sk_dest;
  logic [ID_WIDTH-1:0]   in_id, sk_id;
  logic                  in_last, sk_last;

  // Arbiter: first valid slave starting at rr_ptr (round-robin) or at index 0 (fixed).
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSLAVES; i++) begin
      if (ARB_MODE == 1) cand = IDX_W'((32'(rr_ptr) + i) % NSLAVES);
      else               cand = IDX_W'(i);
      if (!found && s_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Beat acceptance and end-of-grant detection.
  always_comb begin
    push      = (state == XFER) && s_valid[grant] && s_ready[grant];
    pop       = m_valid && m_ready;
    end_grant = push && ((HAS_LAST == 0) || s_last[grant]);
  end

  // Payload selection from the granted slave.
  always_comb begin
    in_data = s_data[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
    in_dest = '0;
    in_id   = '0;
    in_last = 1'b0;
    if (HAS_DEST != 0) in_dest = s_dest[32'(grant)*DEST_WIDTH +: DEST_WIDTH];
    if (ID_SRC != 0)      in_id = ID_WIDTH'(grant);
    else if (HAS_ID != 0) in_id = s_id[32'(grant)*ID_WIDTH +: ID_WIDTH];
    if (HAS_LAST != 0) in_last = s_last[grant];
  end

  // Next-state logic; s_ready is precomputed from next state/grant/occupancy so it can be registered.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    count_nxt   = count;
    s_ready_nxt = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (end_grant) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (32'(grant) == NSLAVES - 1) ? '0 : grant + IDX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (push && !pop)      count_nxt = count + 2'd1;
    else if (!push && pop) count_nxt = count - 2'd1;
    if ((state_nxt == XFER) && (count_nxt < 2'd2)) s_ready_nxt[grant_nxt] = 1'b1;
  end

  // FSM and arbitration state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      s_ready <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
      s_ready <= s_ready_nxt;
    end
  end

  // Output slice: head entry drives m_*, second entry absorbs one beat of backpressure.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count   <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_dest  <= '0;
      m_id    <= '0;
      m_last  <= 1'b0;
      sk_data <= '0;
      sk_dest <= '0;
      sk_id   <= '0;
      sk_last <= 1'b0;
    end else begin
      count   <= count_nxt;
      m_valid <= (count_nxt != 2'd0);
      case (count)
        2'd0: begin
          if (push) begin
            m_data <= in_data; m_dest <= in_dest; m_id <= in_id; m_last <= in_last;
          end
        end
        2'd1: begin
          if (push && pop) begin
            m_data <= in_data; m_dest <= in_dest; m_id <= in_id; m_last <= in_last;
          end else if (push) begin
            sk_data <= in_data; sk_dest <= in_dest; sk_id <= in_id; sk_last <= in_last;
          end
        end
        default: begin
          if (pop) begin
            m_data <= sk_data; m_dest <= sk_dest; m_id <= sk_id; m_last <= sk_last;
            if (push) begin
              sk_data <= in_data; sk_dest <= in_dest; sk_id <= in_id; sk_last <= in_last;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_switch_rr_master.sv
// Directed testbench for axis_switch_rr_master. Two instances share the slave-side
// stimulus: u_rr (round-robin, TID = source index, packet lock, TDEST forwarded) and
// u_fp (fixed priority, single-beat grants, TID forwarded). use_fp picks which one
// the source model and output collector follow.
module tb_axis_switch_rr_master;

  localparam int unsigned NS  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned DSW = 2;
  localparam int unsigned IW  = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic [NS-1:0]     s_valid, s_last;
  logic [NS*DW-1:0]  s_data;
  logic [NS*DSW-1:0] s_dest;
  logic [NS*IW-1:0]  s_id;
  logic              m_ready;

  logic [NS-1:0] s_ready_rr, s_ready_fp, s_ready_act;
  logic          m_valid_rr, m_valid_fp, m_valid_act;
  logic [DW-1:0] m_data_rr, m_data_fp, m_data_act;
  logic [DSW-1:0] m_dest_rr, m_dest_fp, m_dest_act;
  logic [IW-1:0] m_id_rr, m_id_fp, m_id_act;
  logic          m_last_rr, m_last_fp, m_last_act;
  logic          use_fp;

  always #5 aclk = ~aclk;

  axis_switch_rr_master #(
    .NSLAVES(NS), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW),
    .HAS_DEST(1), .HAS_LAST(1), .HAS_ID(0), .ARB_MODE(1), .ID_SRC(1)
  ) u_rr (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready_rr), .s_data(s_data), .s_dest(s_dest),
    .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid_rr), .m_ready(m_ready), .m_data(m_data_rr), .m_dest(m_dest_rr),
    .m_id(m_id_rr), .m_last(m_last_rr)
  );

  axis_switch_rr_master #(
    .NSLAVES(NS), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW),
    .HAS_DEST(0), .HAS_LAST(0), .HAS_ID(1), .ARB_MODE(0), .ID_SRC(0)
  ) u_fp (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready_fp), .s_data(s_data), .s_dest(s_dest),
    .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid_fp), .m_ready(m_ready), .m_data(m_data_fp), .m_dest(m_dest_fp),
    .m_id(m_id_fp), .m_last(m_last_fp)
  );

  assign s_ready_act = use_fp ? s_ready_fp : s_ready_rr;
  assign m_valid_act = use_fp ? m_valid_fp : m_valid_rr;
  assign m_data_act  = use_fp ? m_data_fp  : m_data_rr;
  assign m_dest_act  = use_fp ? m_dest_fp  : m_dest_rr;
  assign m_id_act    = use_fp ? m_id_fp    : m_id_rr;
  assign m_last_act  = use_fp ? m_last_fp  : m_last_rr;

  // Source model state: next data count, beat index in packet, packet length, packets left.
  int cnt[NS];
  int bidx[NS];
  int plen[NS];
  int pkts[NS];
  int cyc;
  int n_assert;
  int n_fail;

  logic [DW-1:0]  q_data[$];
  logic [IW-1:0]  q_id[$];
  logic [DSW-1:0] q_dest[$];
  logic           q_last[$];
  int             q_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int j = 0; j < NS; j++) begin
      s_valid[j]             = (pkts[j] > 0);
      s_data[j*DW +: DW]     = DW'((j << 12) | cnt[j]);
      s_last[j]              = (bidx[j] == plen[j] - 1);
      s_dest[j*DSW +: DSW]   = DSW'(j);
      s_id[j*IW +: IW]       = IW'(3 - j);
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance, update sources.
  task automatic tick();
    logic [NS-1:0] acc;
    logic          pop;
    acc = s_valid & s_ready_act & {NS{aresetn}};
    pop = m_valid_act & m_ready & aresetn;
    if (pop) begin
      q_data.push_back(m_data_act);
      q_id.push_back(m_id_act);
      q_dest.push_back(m_dest_act);
      q_last.push_back(m_last_act);
      q_cyc.push_back(cyc);
    end
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
    for (int j = 0; j < NS; j++) begin
      if (acc[j]) begin
        cnt[j]++;
        if (bidx[j] == plen[j] - 1) begin
          bidx[j] = 0;
          pkts[j]--;
        end else begin
          bidx[j]++;
        end
      end
    end
    drive();
  endtask

  task automatic clear_q();
    q_data.delete(); q_id.delete(); q_dest.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    repeat (n) tick();
    aresetn = 1'b1;
    clear_q();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (q_data.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk({tag, "_beat_count"}, q_data.size(), n);
  endtask

  initial begin
    int started;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    use_fp   = 1'b0;
    aresetn  = 1'b0;
    m_ready  = 1'b1;
    for (int j = 0; j < NS; j++) begin
      cnt[j] = 0; bidx[j] = 0; plen[j] = 1; pkts[j] = 2;
    end
    drive();

    // Reset held 3 cycles with every slave requesting.
    repeat (3) begin
      tick();
      chk("t1_rst_m_valid", m_valid_rr, 0);
      chk("t1_rst_s_ready", s_ready_rr, 0);
    end
    chk("t1_rst_m_data", m_data_rr, 0);
    aresetn = 1'b1;
    chk("t1_idle_s_ready", s_ready_rr, 0);
    tick();
    chk("t1_grant0_s_ready", s_ready_rr, 4'b0001);
    chk("t1_bubble_m_valid", m_valid_rr, 0);

    // Round-robin over four always-valid slaves, one beat per grant.
    wait_beats(8, 60, "t2");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_id[%0d]", k), q_id[k], k % 4);
      chk($sformatf("t2_data[%0d]", k), q_data[k], ((k % 4) << 12) | (k / 4));
      chk($sformatf("t2_dest[%0d]", k), q_dest[k], k % 4);
    end

    // Packet lock: slave2 5-beat packet, slave0 requests from beat 2.
    pkts[2] = 1; plen[2] = 5; cnt[2] = 'h10; bidx[2] = 0;
    drive();
    do_reset(1);
    started = 0;
    for (int c = 0; c < 60 && q_data.size() < 7; c++) begin
      tick();
      if (started == 0 && bidx[2] >= 1) begin
        started = 1;
        pkts[0] = 1; plen[0] = 2; cnt[0] = 'h20; bidx[0] = 0;
        drive();
      end else if (started != 0 && pkts[2] > 0) begin
        chk("t3_s_ready0_locked_out", s_ready_rr[0], 0);
      end
    end
    chk("t3_beat_count", q_data.size(), 7);
    begin
      logic [15:0] ed[7];
      logic [1:0]  ei[7];
      logic        el[7];
      ed = '{16'h2010, 16'h2011, 16'h2012, 16'h2013, 16'h2014, 16'h0020, 16'h0021};
      ei = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
      el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 7; k++) begin
        chk($sformatf("t3_data[%0d]", k), q_data[k], ed[k]);
        chk($sformatf("t3_id[%0d]", k), q_id[k], ei[k]);
        chk($sformatf("t3_last[%0d]", k), q_last[k], el[k]);
      end
    end

    // Backpressure: stall 4 cycles after three beats of an 8-beat packet.
    clear_q();
    pkts[0] = 1; plen[0] = 8; cnt[0] = 'h10; bidx[0] = 0;
    drive();
    wait_beats(3, 30, "t4a");
    m_ready = 1'b0;
    repeat (4) tick();
    chk("t4_stall_s_ready0", s_ready_rr[0], 0);
    chk("t4_stall_m_valid", m_valid_rr, 1);
    chk("t4_stall_m_data", m_data_rr, 16'h0013);
    m_ready = 1'b1;
    wait_beats(8, 30, "t4b");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_data[%0d]", k), q_data[k], 16'h0010 + k);
      chk($sformatf("t4_last[%0d]", k), q_last[k], (k == 7) ? 1 : 0);
      if (k != 0 && k != 3)
        chk($sformatf("t4_gap[%0d]", k), q_cyc[k] - q_cyc[k-1], 1);
    end

    // Fixed priority: slaves 1 and 3 always valid, only slave 1 is served.
    use_fp = 1'b1;
    for (int j = 0; j < NS; j++) pkts[j] = 0;
    pkts[1] = 8; plen[1] = 1; cnt[1] = 0;    bidx[1] = 0;
    pkts[3] = 8; plen[3] = 1; cnt[3] = 'h30; bidx[3] = 0;
    drive();
    do_reset(1);
    wait_beats(5, 40, "t5");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5_data[%0d]", k), q_data[k], 16'h1000 + k);
      chk($sformatf("t5_id[%0d]", k), q_id[k], 2);
      chk($sformatf("t5_last[%0d]", k), q_last[k], 0);
      chk($sformatf("t5_dest[%0d]", k), q_dest[k], 0);
    end

    // Reset in the middle of a packet: in-flight beats dropped, pointer back to 0.
    use_fp = 1'b0;
    for (int j = 0; j < NS; j++) pkts[j] = 0;
    pkts[2] = 1; plen[2] = 1; cnt[2] = 'h50; bidx[2] = 0;
    pkts[3] = 1; plen[3] = 6; cnt[3] = 'h30; bidx[3] = 0;
    drive();
    do_reset(1);
    for (int c = 0; c < 30 && bidx[3] < 2; c++) tick();
    chk("t6_pre_slave3_beats", bidx[3], 2);
    chk("t6_first_id", q_id[0], 2);
    chk("t6_first_data", q_data[0], 16'h2050);
    aresetn = 1'b0;
    tick();
    chk("t6_rst_m_valid", m_valid_rr, 0);
    chk("t6_rst_s_ready", s_ready_rr, 0);
    chk("t6_rst_m_data", m_data_rr, 0);
    aresetn = 1'b1;
    pkts[1] = 1; plen[1] = 1; cnt[1] = 'h40; bidx[1] = 0;
    drive();
    clear_q();
    wait_beats(1, 20, "t6");
    chk("t6_after_id", q_id[0], 1);
    chk("t6_after_data", q_data[0], 16'h1040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
